// File: rtl/vmicro16_apb_pkg.sv
// Shared definitions for the vmicro16 per-core APB master bridge.
package vmicro16_apb_pkg;

  // Bridge FSM encoding; values are fixed so other vmicro16 blocks can decode them.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned DefaultBusWidth      = 16;
  localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for the APB master bridge.
// tc is high while the count sits at Limit-1, i.e. the last permitted wait cycle.
module apb_timeout_ctr #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;

  // Clear wins over count; hold at the terminal value rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Terminal count decode.
  always_comb begin
    tc = (cnt_q == CntW'(Limit - 1));
  end

endmodule

// File: rtl/vmicro16_apb_master.sv
// Per-core APB master bridge: one core load/store becomes one two-phase APB transfer.
// Optional macro APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES waits.
module vmicro16_apb_master
  import vmicro16_apb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DefaultBusWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vmicro16_apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e state;
  logic       timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic ctr_clr;
  logic ctr_en;
  logic ctr_tc;

  // Counter restarts on every accepted request and counts only stalled ACCESS cycles.
  always_comb begin
    ctr_clr     = (state == StIdle) && req_valid;
    ctr_en      = (state == StAccess) && !M_PREADY;
    timeout_hit = ctr_tc;
  end

  apb_timeout_ctr #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );
`else
  // Without the timeout feature ACCESS waits for M_PREADY indefinitely.
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Core handshake: a request is only taken in IDLE.
  always_comb begin
    req_ready = (state == StIdle);
  end

  // Bridge FSM with all APB and response outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      M_PADDR    <= '0;
      M_PWRITE   <= 1'b0;
      M_PWDATA   <= '0;
      M_PSELx    <= 1'b0;
      M_PENABLE  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            M_PADDR  <= req_addr;
            M_PWRITE <= req_write;
            M_PWDATA <= req_wdata;
            M_PSELx  <= 1'b1;
            state    <= StSetup;
          end
        end
        StSetup: begin
          M_PENABLE <= 1'b1;
          state     <= StAccess;
        end
        StAccess: begin
          // A ready slave on the limit edge still completes normally.
          if (M_PREADY) begin
            M_PSELx    <= 1'b0;
            M_PENABLE  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= M_PWRITE ? '0 : M_PRDATA;
            resp_err   <= 1'b0;
            state      <= StIdle;
          end else if (timeout_hit) begin
            M_PSELx    <= 1'b0;
            M_PENABLE  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= StIdle;
          end
        end
        default: begin
          M_PSELx   <= 1'b0;
          M_PENABLE <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Self-checking bench for vmicro16_apb_master: table-driven transfers with a response
// scoreboard, plus hand-written reset, stall and timeout sequences.
module tb_vmicro16_apb_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] M_PADDR;
  logic        M_PWRITE;
  logic        M_PSELx;
  logic        M_PENABLE;
  logic [15:0] M_PWDATA;
  logic [15:0] M_PRDATA;
  logic        M_PREADY;

  vmicro16_apb_master #(
    .BUS_WIDTH      (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .M_PADDR    (M_PADDR),
    .M_PWRITE   (M_PWRITE),
    .M_PSELx    (M_PSELx),
    .M_PENABLE  (M_PENABLE),
    .M_PWDATA   (M_PWDATA),
    .M_PRDATA   (M_PRDATA),
    .M_PREADY   (M_PREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] prdata;
    int          waits;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; any response seen is popped from the scoreboard and compared.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response", resp_rdata);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One complete transfer with exact phase timing checks.
  task automatic xfer(input vec_t v);
    exp_t e;
    wait_ready();
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    e.rdata   = v.wr ? 16'h0000 : v.prdata;
    e.err     = 1'b0;
    sb.push_back(e);
    step();
    acc_cyc = cyc;
    // SETUP; request inputs scrambled to prove they were latched.
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_write = ~v.wr;
    M_PRDATA  = v.prdata;
    M_PREADY  = 1'b1;
    chk("setup_psel", 32'(M_PSELx), 32'd1);
    chk("setup_penable", 32'(M_PENABLE), 32'd0);
    chk("setup_paddr", 32'(M_PADDR), 32'(v.addr));
    chk("setup_ready", 32'(req_ready), 32'd0);
    step();
    for (int k = 0; k <= v.waits; k++) begin
      req_valid = 1'b0;
      req_addr  = ~v.addr;
      M_PREADY  = (k == v.waits);
      chk("access_psel", 32'(M_PSELx), 32'd1);
      chk("access_penable", 32'(M_PENABLE), 32'd1);
      chk("access_paddr", 32'(M_PADDR), 32'(v.addr));
      chk("access_pwrite", 32'(M_PWRITE), 32'(v.wr));
      chk("access_pwdata", 32'(M_PWDATA), 32'(v.wdata));
      chk("access_no_resp", 32'(resp_valid), 32'd0);
      if (v.busy && k == 0) begin
        req_valid = 1'b1;
        req_addr  = 16'h00C0;
      end
      step();
    end
    req_valid = 1'b0;
    M_PREADY  = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_psel", 32'(M_PSELx), 32'd0);
    chk("resp_penable", 32'(M_PENABLE), 32'd0);
    chk("resp_req_ready", 32'(req_ready), 32'd1);
    chk("idle_paddr_held", 32'(M_PADDR), 32'(v.addr));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_acc;
    int prev_waits;
    exp_t e;
    vecs[0] = '{wr: 1'b0, addr: 16'h0080, wdata: 16'h0000, prdata: 16'h1234, waits: 0, busy: 1'b0};
    vecs[1] = '{wr: 1'b1, addr: 16'h00A0, wdata: 16'h00FF, prdata: 16'hDEAD, waits: 2, busy: 1'b0};
    vecs[2] = '{wr: 1'b0, addr: 16'h0100, wdata: 16'h1111, prdata: 16'hBEEF, waits: 1, busy: 1'b0};
    vecs[3] = '{wr: 1'b1, addr: 16'h0200, wdata: 16'h5A5A, prdata: 16'h7777, waits: 0, busy: 1'b0};
    vecs[4] = '{wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0F0F, prdata: 16'h8001, waits: 3, busy: 1'b1};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    M_PRDATA  = 16'h0;
    M_PREADY  = 1'b0;

    // Reset state.
    #12;
    chk("rst_psel", 32'(M_PSELx), 32'd0);
    chk("rst_penable", 32'(M_PENABLE), 32'd0);
    chk("rst_paddr", 32'(M_PADDR), 32'd0);
    chk("rst_pwdata", 32'(M_PWDATA), 32'd0);
    chk("rst_pwrite", 32'(M_PWRITE), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Table of back-to-back transfers; each accept follows the previous by 3 + waits cycles.
    prev_acc   = 0;
    prev_waits = 0;
    for (int i = 0; i < 5; i++) begin
      xfer(vecs[i]);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(3 + prev_waits));
      prev_acc   = acc_cyc;
      prev_waits = vecs[i].waits;
    end
    step();
    chk("idle_no_psel", 32'(M_PSELx), 32'd0);

    // Stalled ACCESS with M_PREADY held low.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0300;
`ifdef APB_MASTER_TIMEOUT_EN
    e.rdata = 16'h0000;
    e.err   = 1'b1;
`else
    e.rdata = 16'h4321;
    e.err   = 1'b0;
`endif
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    M_PRDATA  = 16'h4321;
    M_PREADY  = 1'b0;
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      chk("to_penable", 32'(M_PENABLE), 32'd1);
      chk("to_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_psel_drop", 32'(M_PSELx), 32'd0);
    chk("to_ready", 32'(req_ready), 32'd1);
`else
    for (int k = 0; k < 20; k++) begin
      chk("stall_penable", 32'(M_PENABLE), 32'd1);
      chk("stall_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    M_PREADY = 1'b1;
    step();
    M_PREADY = 1'b0;
    chk("stall_resp_valid", 32'(resp_valid), 32'd1);
`endif
    chk("stall_sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of ACCESS: no response for that transfer.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0400;
    req_wdata = 16'hA5A5;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_penable", 32'(M_PENABLE), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_psel", 32'(M_PSELx), 32'd0);
    chk("arst_penable", 32'(M_PENABLE), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("arst_no_resp", 32'(resp_valid), 32'd0);
      chk("arst_ready_idle", 32'(req_ready), 32'd1);
    end

    // Bridge is usable again after reset.
    xfer(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
